// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: requests the bus, shifts one command byte out
// on device clock edges, checks the device ACK, and reports done/error pulses.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       kb_clock_in,
  input  logic       kb_data_in,
  output logic       kb_clock_oe,
  output logic       kb_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FLT_W = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;

  state_t             state;
  logic               clk_meta, clk_sync, dat_meta, dat_sync;
  logic               fclk, fclk_q;
  logic [FLT_W-1:0]   flt_cnt;
  logic [INH_W-1:0]   inh_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [3:0]         bit_cnt;
  logic [8:0]         frame;
  logic               fall;
  logic               timeout;

  // Idle PS/2 lines are pulled high, so synchronizers and filter start at 1.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= kb_clock_in;
      clk_sync <= clk_meta;
      dat_meta <= kb_data_in;
      dat_sync <= dat_meta;
    end
  end

  // Filtered clock only follows after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fclk    <= 1'b1;
      fclk_q  <= 1'b1;
      flt_cnt <= '0;
    end else begin
      fclk_q <= fclk;
      if (clk_sync == fclk) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
        fclk    <= clk_sync;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign fall    = fclk_q & ~fclk;
  assign timeout = (state == SEND || state == ACK || state == WAIT_IDLE) &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      kb_clock_oe <= 1'b0;
      kb_data_oe  <= 1'b0;
      busy        <= 1'b0;
      tx_ready    <= 1'b1;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      inh_cnt     <= '0;
      tmo_cnt     <= '0;
      bit_cnt     <= '0;
      frame       <= '0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      // Timeout wins over any edge seen in the same cycle.
      if (timeout) begin
        state       <= IDLE;
        kb_clock_oe <= 1'b0;
        kb_data_oe  <= 1'b0;
        busy        <= 1'b0;
        tx_ready    <= 1'b1;
        tx_error    <= 1'b1;
      end else begin
        if (state == SEND || state == ACK || state == WAIT_IDLE)
          tmo_cnt <= tmo_cnt + 1'b1;
        case (state)
          IDLE: begin
            if (tx_valid) begin
              frame       <= {~^tx_data, tx_data};
              inh_cnt     <= '0;
              tmo_cnt     <= '0;
              bit_cnt     <= '0;
              kb_clock_oe <= 1'b1;
              busy        <= 1'b1;
              tx_ready    <= 1'b0;
              state       <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
              kb_data_oe <= 1'b1;
              state      <= REQ;
            end else begin
              inh_cnt <= inh_cnt + 1'b1;
            end
          end
          REQ: begin
            kb_clock_oe <= 1'b0;
            tmo_cnt     <= '0;
            state       <= SEND;
          end
          SEND: begin
            // Edges 1..9 shift out data then parity; edge 10 releases data for the stop bit.
            if (fall) begin
              if (bit_cnt == 4'd9) begin
                kb_data_oe <= 1'b0;
                state      <= ACK;
              end else begin
                kb_data_oe <= ~frame[0];
                frame      <= {1'b0, frame[8:1]};
                bit_cnt    <= bit_cnt + 1'b1;
              end
            end
          end
          ACK: begin
            if (fall) begin
              if (!dat_sync) begin
                state <= WAIT_IDLE;
              end else begin
                state    <= IDLE;
                busy     <= 1'b0;
                tx_ready <= 1'b1;
                tx_error <= 1'b1;
              end
            end
          end
          WAIT_IDLE: begin
            if (fclk && dat_sync) begin
              state    <= IDLE;
              busy     <= 1'b0;
              tx_ready <= 1'b1;
              tx_done  <= 1'b1;
            end
          end
          default: begin
            state       <= IDLE;
            kb_clock_oe <= 1'b0;
            kb_data_oe  <= 1'b0;
            busy        <= 1'b0;
            tx_ready    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 keyboard that clocks
// the frame in, records the bits it samples and optionally ACKs.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TMO  = 4000;
  localparam int FL   = 4;
  localparam int HALF = 40;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       kb_clock_in, kb_data_in;
  logic       kb_clock_oe, kb_data_oe;
  logic       busy, tx_done, tx_error;

  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int accept_cnt = 0;
  logic busy_q = 1'b0;

  assign kb_clock_in = ~(kb_clock_oe | dev_clk_low);
  assign kb_data_in  = ~(kb_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN(FL)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .kb_clock_in(kb_clock_in),
    .kb_data_in(kb_data_in),
    .kb_clock_oe(kb_clock_oe),
    .kb_data_oe(kb_data_oe),
    .busy(busy),
    .tx_done(tx_done),
    .tx_error(tx_error)
  );

  always #5 clock = ~clock;

  // Pulse and accept bookkeeping, sampled away from the active edge.
  always @(negedge clock) begin
    busy_q <= busy;
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_error) err_cnt <= err_cnt + 1;
    if (busy && !busy_q) accept_cnt <= accept_cnt + 1;
  end

  task automatic start_tx(input logic [7:0] data, input bit hold, output int inh, output int req);
    int t;
    t = 0;
    tx_data = data;
    tx_valid = 1'b1;
    @(negedge clock);
    while (!busy && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (!hold) tx_valid = 1'b0;
    inh = 0;
    while (kb_clock_oe && !kb_data_oe && inh < 100) begin
      inh++;
      @(negedge clock);
    end
    req = 0;
    while (kb_clock_oe && kb_data_oe && req < 100) begin
      req++;
      @(negedge clock);
    end
  endtask

  task automatic device(input int nfalls, input bit ack, input bit glitch, output logic [10:0] s);
    int t;
    t = 0;
    s = 'x;
    while (!(kb_clock_oe === 1'b0 && kb_data_oe === 1'b1) && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (t >= 300) return;
    s[0] = kb_data_in;
    if (glitch) begin
      repeat (10) @(negedge clock);
      dev_clk_low = 1'b1;
      repeat (2) @(negedge clock);
      dev_clk_low = 1'b0;
    end
    repeat (HALF) @(negedge clock);
    for (int i = 1; i <= nfalls; i++) begin
      dev_clk_low = 1'b1;
      if (i == 11) dev_data_low = ack;
      repeat (HALF) @(negedge clock);
      dev_clk_low = 1'b0;
      if (i <= 10) s[i] = kb_data_in;
      repeat (HALF) @(negedge clock);
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 300) begin
      @(negedge clock);
      t++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if ({kb_clock_oe, kb_data_oe, busy, tx_ready, tx_done, tx_error} !== 6'b000100) begin
      bad++;
      $display("[TB] FAIL reset_hold: got=%b want=000100",
               {kb_clock_oe, kb_data_oe, busy, tx_ready, tx_done, tx_error});
    end
    resetn = 1'b1;
    repeat (5) @(negedge clock);
    total++;
    if ({kb_clock_oe, kb_data_oe, busy, tx_ready, tx_done, tx_error} !== 6'b000100 ||
        done_cnt != 0 || err_cnt != 0) begin
      bad++;
      $display("[TB] FAIL reset_release: got=%b done=%0d err=%0d want=000100 0 0",
               {kb_clock_oe, kb_data_oe, busy, tx_ready, tx_done, tx_error}, done_cnt, err_cnt);
    end
  endtask

  task automatic test_send_ed();
    int inh, req, d0, e0;
    logic [10:0] s;
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'hED, 1'b0, inh, req);
    total++;
    if (inh != INH) begin
      bad++;
      $display("[TB] FAIL ed_inhibit: got=%0d want=%0d", inh, INH);
    end
    total++;
    if (req != 1) begin
      bad++;
      $display("[TB] FAIL ed_req: got=%0d want=1", req);
    end
    device(11, 1'b1, 1'b0, s);
    total++;
    if (s !== 11'b11111011010) begin
      bad++;
      $display("[TB] FAIL ed_samples: got=%b want=11111011010", s);
    end
    wait_idle();
    total++;
    if (tx_done !== 1'b1 || tx_ready !== 1'b1 || tx_error !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ed_done: done=%b ready=%b err=%b want 1 1 0", tx_done, tx_ready, tx_error);
    end
    repeat (3) @(negedge clock);
    total++;
    if (done_cnt - d0 != 1 || err_cnt != e0) begin
      bad++;
      $display("[TB] FAIL ed_pulses: done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_back_to_back();
    int inh, req, a0;
    logic [10:0] s;
    a0 = accept_cnt;
    start_tx(8'hF4, 1'b1, inh, req);
    device(11, 1'b1, 1'b0, s);
    total++;
    if (s !== 11'b10111101000) begin
      bad++;
      $display("[TB] FAIL f4_samples: got=%b want=10111101000", s);
    end
    wait_idle();
    total++;
    if (tx_done !== 1'b1 || tx_ready !== 1'b1 || accept_cnt - a0 != 1) begin
      bad++;
      $display("[TB] FAIL f4_first_done: done=%b ready=%b accepts=%0d want 1 1 1",
               tx_done, tx_ready, accept_cnt - a0);
    end
    @(negedge clock);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL f4_reaccept: busy=%b want=1", busy);
    end
    tx_valid = 1'b0;
    tx_data = 8'h00;
    device(11, 1'b1, 1'b0, s);
    total++;
    if (s !== 11'b10111101000) begin
      bad++;
      $display("[TB] FAIL f4_second_samples: got=%b want=10111101000", s);
    end
    wait_idle();
    repeat (3) @(negedge clock);
    total++;
    if (accept_cnt - a0 != 2 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL f4_accepts: got=%0d busy=%b want=2 0", accept_cnt - a0, busy);
    end
  endtask

  task automatic test_no_ack();
    int inh, req, d0, e0;
    logic [10:0] s;
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'hED, 1'b0, inh, req);
    device(11, 1'b0, 1'b0, s);
    wait_idle();
    repeat (3) @(negedge clock);
    total++;
    if (err_cnt - e0 != 1 || done_cnt != d0) begin
      bad++;
      $display("[TB] FAIL noack_pulses: err=%0d done=%0d want 1 0", err_cnt - e0, done_cnt - d0);
    end
    total++;
    if ({kb_clock_oe, kb_data_oe, busy, tx_ready} !== 4'b0001) begin
      bad++;
      $display("[TB] FAIL noack_lines: got=%b want=0001", {kb_clock_oe, kb_data_oe, busy, tx_ready});
    end
  endtask

  task automatic test_timeout();
    int inh, req, n, d0;
    d0 = done_cnt;
    start_tx(8'hFF, 1'b0, inh, req);
    n = 0;
    while (!tx_error && n < TMO + 1000) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (n != TMO) begin
      bad++;
      $display("[TB] FAIL timeout_cycles: got=%0d want=%0d", n, TMO);
    end
    total++;
    if ({kb_clock_oe, kb_data_oe, busy, tx_ready, tx_done} !== 5'b00010) begin
      bad++;
      $display("[TB] FAIL timeout_state: got=%b want=00010",
               {kb_clock_oe, kb_data_oe, busy, tx_ready, tx_done});
    end
    repeat (3) @(negedge clock);
    total++;
    if (done_cnt != d0) begin
      bad++;
      $display("[TB] FAIL timeout_no_done: got=%0d want=0", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int inh, req, d0, e0;
    logic [10:0] s;
    start_tx(8'hED, 1'b0, inh, req);
    device(5, 1'b0, 1'b0, s);
    total++;
    if (kb_data_oe !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midreset_pre: data_oe=%b busy=%b want 1 1", kb_data_oe, busy);
    end
    d0 = done_cnt;
    e0 = err_cnt;
    #2 resetn = 1'b0;
    #1;
    total++;
    if ({kb_clock_oe, kb_data_oe, busy} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL midreset_release: got=%b want=000", {kb_clock_oe, kb_data_oe, busy});
    end
    @(negedge clock);
    resetn = 1'b1;
    repeat (5) @(negedge clock);
    total++;
    if (done_cnt != d0 || err_cnt != e0 || tx_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midreset_pulses: done=%0d err=%0d ready=%b want 0 0 1",
               done_cnt - d0, err_cnt - e0, tx_ready);
    end
    d0 = done_cnt;
    start_tx(8'hFF, 1'b0, inh, req);
    device(11, 1'b1, 1'b0, s);
    total++;
    if (s !== 11'b11111111110) begin
      bad++;
      $display("[TB] FAIL ff_samples: got=%b want=11111111110", s);
    end
    wait_idle();
    repeat (3) @(negedge clock);
    total++;
    if (done_cnt - d0 != 1) begin
      bad++;
      $display("[TB] FAIL ff_done: got=%0d want=1", done_cnt - d0);
    end
  endtask

  task automatic test_glitch();
    int inh, req, d0;
    logic [10:0] s;
    d0 = done_cnt;
    start_tx(8'hA5, 1'b0, inh, req);
    device(11, 1'b1, 1'b1, s);
    total++;
    if (s !== 11'b11101001010) begin
      bad++;
      $display("[TB] FAIL glitch_samples: got=%b want=11101001010", s);
    end
    wait_idle();
    repeat (3) @(negedge clock);
    total++;
    if (done_cnt - d0 != 1) begin
      bad++;
      $display("[TB] FAIL glitch_done: got=%0d want=1", done_cnt - d0);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_send_ed();
    test_back_to_back();
    test_no_ack();
    test_timeout();
    test_reset_mid_frame();
    test_glitch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
